smpte_bar_gen: RTL and testbench
================================

# smpte_bar_gen

Source stage of the YC test-pattern core. Produces 15 kHz NTSC/PAL (or 31 kHz scan-doubled) raster timing, a pixel enable, and an 8-bar colour pattern with selectable 75 %/100 % amplitude and limited/full range. Its outputs drive the core's VGA_R/G/B, HS/VS, DE and CE_PIXEL, which feed the RGBS/YPbPr and Y/C encoders.

## Interface
- CE_DIV, 4: clk cycles per pixel in 15 kHz mode; even, ≥ 2. Scan-doubled mode uses CE_DIV/2.
- clk  in  1  pattern clock; every register is clocked here.
- reset  in  1  synchronous, active-high.
- pal  in  1  0 = NTSC geometry, 1 = PAL geometry; sampled at frame start.
- range  in  1  0 = limited (16..235), 1 = full (0..255); sampled at frame start.
- smpte  in  1  0 = 75 % bars, 1 = 100 % bars; sampled at frame start.
- scandouble  in  1  1 = 31 kHz line rate; sampled at frame start.
- ce_pix  out  1  one-clk pixel strobe.
- HBlank, HSync, VBlank, VSync  out  1 each  active-high.
- video_r, video_g, video_b  out  8 each  pixel colour.

## Operation
- Clock divider: counts 0..D-1, where D = CE_DIV or CE_DIV/2. ce_pix = 1 when the count is D-1.
- hcount 0..857 advances on ce_pix and wraps to 0. On wrap, vcount advances.
- vcount wraps at VT-1, where VT = 262 (NTSC), 312 (PAL); doubled to 524/624 in scandouble mode.
- Frame start is the vcount wrap. pal/range/smpte/scandouble are latched only there, so geometry never changes mid-frame.
- HBlank = hcount ≥ 720. HSync = 736 ≤ hcount < 800.
- VBlank = vcount ≥ VA, where VA = 240/288 (480/576 doubled).
- VSync = VS0 ≤ vcount < VS0+3, where VS0 = 244/290; doubled mode uses 488/580 with length 6.
- Pattern row: pr = scandouble ? vcount>>1 : vcount.
- Pattern column: bar = hcount/90 (0..7). Compute with compare chain or counter; no divider.
- Bar colour, bits {R,G,B}: 0 white 111, 1 yellow 110, 2 cyan 011, 3 green 010, 4 magenta 101, 5 red 100, 6 blue 001, 7 black 000.
- Component level: bit=1 → HI, bit=0 → LO.
  - HI: full/100 = 255, full/75 = 191, limited/100 = 235, limited/75 = 180.
  - LO: 0 full, 16 limited.
- While HBlank or VBlank is 1, video_r/g/b = 0 regardless of range.

## Timing
- Reset: divider, hcount and vcount = 0. All outputs = 0 (ce_pix, syncs, blanks, RGB). Latches load NTSC/limited/75 %/15 kHz.
- First ce_pix comes D cycles after reset deasserts.
- Outputs are registered and update only in the clk cycle where ce_pix = 1. They reflect the hcount/vcount value held before that increment.
- Latency: one pixel from counter to output.
- A reset asserted mid-line or mid-frame takes effect on the next clk edge, with no partial-pixel completion.
- Input changes mid-frame have no effect until the next frame start. A change within the frame-start ce cycle itself is captured.

## Configuration
- TESTPAT_RAMP_EN defined:
  - Active rows with pr ≥ 180 (NTSC) or pr ≥ 216 (PAL) show a grey ramp, replacing the bars.
  - Each component = clamp(hcount[9:2], LO, HI).
- Not defined: bars occupy the full active area and no ramp logic is synthesised.

## Test plan
- Reset with pal = 0, scandouble = 0, CE_DIV = 4 → ce_pix period 4 clks; HSync period 858 ce; VSync period 262 lines; HSync width 64 ce; VSync width 3 lines.
- pal = 1, smpte = 1, range = 1 → 312 lines/frame. Pixel (hcount 100, row 10) reads R = 255, G = 255, B = 0 (yellow). hcount 719 reads 0,0,0.
- range = 0, smpte = 0 → white bar reads 180,180,180. Black bar and blanking read 16 and 0 respectively.
- Toggle pal at vcount 100 → the current frame still wraps at 262; the next frame wraps at 312.
- scandouble = 1 → ce_pix every 2 clks, 524 lines/frame, VSync 6 lines. Rows 2n and 2n+1 are identical.
- Assert reset at hcount 400 → next clk all outputs are 0 and the counters restart from 0. With TESTPAT_RAMP_EN, NTSC pr 200, hcount 400 → all components = 100.

Source files
------------

// File: rtl/smpte_bar_gen.sv
// Raster timing and 8-bar colour pattern source for the YC test-pattern core.
// Define TESTPAT_RAMP_EN to replace the lower bars with a clamped grey ramp.
module smpte_bar_gen #(
  parameter int CE_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pal,
  input  logic       range,
  input  logic       smpte,
  input  logic       scandouble,
  output logic       ce_pix,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic [7:0] video_r,
  output logic [7:0] video_g,
  output logic [7:0] video_b
);
  localparam int DW = $clog2(CE_DIV) + 1;

  logic [DW-1:0] r_div;
  logic [9:0]    r_h, r_v;
  logic          r_pal, r_rng, r_smp, r_sd;
  logic          r_hb, r_hs, r_vb, r_vs;
  logic [7:0]    r_r, r_g, r_b;

  logic [DW-1:0] w_dmax;
  logic          w_ce, w_hwrap, w_vwrap;
  logic [9:0]    w_vt, w_va, w_vs0, w_vse;
  logic          w_hb, w_hs, w_vb, w_vs;
  logic [2:0]    w_bar;
  logic [7:0]    w_hi, w_lo, w_r, w_g, w_b;

  assign w_dmax  = r_sd ? DW'(CE_DIV/2 - 1) : DW'(CE_DIV - 1);
  assign w_ce    = (r_div == w_dmax);
  assign w_hwrap = (r_h == 10'd857);

  // Geometry comes only from the frame-start latches, never the live inputs
  always_comb begin
    case ({r_sd, r_pal})
      2'b00:   begin w_vt = 10'd262; w_va = 10'd240; w_vs0 = 10'd244; end
      2'b01:   begin w_vt = 10'd312; w_va = 10'd288; w_vs0 = 10'd290; end
      2'b10:   begin w_vt = 10'd524; w_va = 10'd480; w_vs0 = 10'd488; end
      default: begin w_vt = 10'd624; w_va = 10'd576; w_vs0 = 10'd580; end
    endcase
  end

  assign w_vse   = w_vs0 + (r_sd ? 10'd6 : 10'd3);
  assign w_vwrap = (r_v == w_vt - 10'd1);

  assign w_hb = (r_h >= 10'd720);
  assign w_hs = (r_h >= 10'd736) && (r_h < 10'd800);
  assign w_vb = (r_v >= w_va);
  assign w_vs = (r_v >= w_vs0) && (r_v < w_vse);

  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (r_h >= 10'(90*k)) w_bar = 3'(k);
  end

  assign w_hi = r_rng ? (r_smp ? 8'd255 : 8'd191) : (r_smp ? 8'd235 : 8'd180);
  assign w_lo = r_rng ? 8'd0 : 8'd16;

`ifdef TESTPAT_RAMP_EN
  logic [9:0] w_pr;
  logic       w_ramp;
  logic [7:0] w_ramp_v;
  assign w_pr     = r_sd ? {1'b0, r_v[9:1]} : r_v;
  assign w_ramp   = (w_pr >= (r_pal ? 10'd216 : 10'd180));
  assign w_ramp_v = (r_h[9:2] < w_lo) ? w_lo : (r_h[9:2] > w_hi) ? w_hi : r_h[9:2];
`endif

  // Bar index bits map straight onto inverted colour bits: R=~b1, G=~b2, B=~b0
  always_comb begin
    w_r = w_bar[1] ? w_lo : w_hi;
    w_g = w_bar[2] ? w_lo : w_hi;
    w_b = w_bar[0] ? w_lo : w_hi;
`ifdef TESTPAT_RAMP_EN
    if (w_ramp) begin
      w_r = w_ramp_v;
      w_g = w_ramp_v;
      w_b = w_ramp_v;
    end
`endif
    if (w_hb || w_vb) begin
      w_r = 8'd0;
      w_g = 8'd0;
      w_b = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
      r_pal <= 1'b0;
      r_rng <= 1'b0;
      r_smp <= 1'b0;
      r_sd  <= 1'b0;
      r_hb  <= 1'b0;
      r_hs  <= 1'b0;
      r_vb  <= 1'b0;
      r_vs  <= 1'b0;
      r_r   <= '0;
      r_g   <= '0;
      r_b   <= '0;
    end else begin
      r_div <= w_ce ? '0 : r_div + DW'(1);
      if (w_ce) begin
        r_h <= w_hwrap ? 10'd0 : r_h + 10'd1;
        if (w_hwrap) begin
          r_v <= w_vwrap ? 10'd0 : r_v + 10'd1;
          if (w_vwrap) begin
            r_pal <= pal;
            r_rng <= range;
            r_smp <= smpte;
            r_sd  <= scandouble;
          end
        end
        r_hb <= w_hb;
        r_hs <= w_hs;
        r_vb <= w_vb;
        r_vs <= w_vs;
        r_r  <= w_r;
        r_g  <= w_g;
        r_b  <= w_b;
      end
    end
  end

  assign ce_pix  = w_ce;
  assign HBlank  = r_hb;
  assign HSync   = r_hs;
  assign VBlank  = r_vb;
  assign VSync   = r_vs;
  assign video_r = r_r;
  assign video_g = r_g;
  assign video_b = r_b;
endmodule

// File: tb/tb_smpte_bar_gen.sv
// Directed bench for smpte_bar_gen: timing, colour levels, frame-start latching, reset.
// Line counters are forced to jump near frame boundaries so runs stay short.
module tb_smpte_bar_gen;
  logic       clk = 1'b0;
  logic       reset, pal, range, smpte, scandouble;
  logic       ce_pix, HBlank, HSync, VBlank, VSync;
  logic [7:0] video_r, video_g, video_b;

  int n_chk = 0;
  int n_fail = 0;
  int n;
  int hs_r1, hs_r2, hs_f, hb_r1, hb_f, first_hs;
  logic prev_hs, prev_hb;
  logic [9:0] fh, fv;

  smpte_bar_gen #(.CE_DIV(4)) dut (
    .clk(clk), .reset(reset), .pal(pal), .range(range), .smpte(smpte),
    .scandouble(scandouble), .ce_pix(ce_pix), .HBlank(HBlank), .HSync(HSync),
    .VBlank(VBlank), .VSync(VSync), .video_r(video_r), .video_g(video_g),
    .video_b(video_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    check(tag, 32'({video_r, video_g, video_b}), 32'({r, g, b}));
  endtask

  // Returns at the negedge after the next ce edge: outputs show that pixel
  task automatic px();
    int w = 0;
    while (ce_pix !== 1'b1 && w < 16) begin
      @(negedge clk);
      w++;
    end
    if (ce_pix !== 1'b1) check("ce_timeout", 32'(ce_pix), 32'd1);
    @(negedge clk);
  endtask

  // Load counters on a non-ce edge; the following px() shows pixel (h,v)
  task automatic goto(input int h, input int v);
    px();
    fh = 10'(h);
    fv = 10'(v);
    force dut.r_h = fh;
    force dut.r_v = fv;
    @(negedge clk);
    release dut.r_h;
    release dut.r_v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pal = 1'b0; range = 1'b0; smpte = 1'b0; scandouble = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ce_pix, HBlank, HSync, VBlank, VSync, video_r, video_g, video_b}), 32'd0);
    reset = 1'b0;

    // ce first appears in the 4th clock period (3 rising edges after release)
    n = 0;
    while (ce_pix !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    check("first_ce_edges", 32'(n), 32'd3);
    n = 0;
    do begin @(negedge clk); n++; end while (ce_pix !== 1'b1 && n < 16);
    check("ce_period", 32'(n), 32'd4);
    @(negedge clk);
    check("ce_width", 32'(ce_pix), 32'd0);

    // Horizontal timing measured in ce pulses
    hs_r1 = -1; hs_r2 = -1; hs_f = -1; hb_r1 = -1; hb_f = -1;
    prev_hs = 1'b0; prev_hb = 1'b0;
    for (int k = 1; k <= 1700; k++) begin
      px();
      if (HSync && !prev_hs) begin
        if (hs_r1 < 0) hs_r1 = k; else if (hs_r2 < 0) hs_r2 = k;
      end
      if (!HSync && prev_hs && hs_f < 0) hs_f = k;
      if (HBlank && !prev_hb && hb_r1 < 0) hb_r1 = k;
      if (!HBlank && prev_hb && hb_f < 0) hb_f = k;
      prev_hs = HSync;
      prev_hb = HBlank;
    end
    check("hsync_width", 32'(hs_f - hs_r1), 32'd64);
    check("hsync_period", 32'(hs_r2 - hs_r1), 32'd858);
    check("hblank_width", 32'(hb_f - hb_r1), 32'd138);

    // NTSC, limited, 75 %
    goto(0, 5);    px(); chk_rgb("ntsc_white_h0", 8'd180, 8'd180, 8'd180);
    goto(89, 5);   px(); chk_rgb("ntsc_white_h89", 8'd180, 8'd180, 8'd180);
    goto(90, 5);   px(); chk_rgb("ntsc_yellow_h90", 8'd180, 8'd180, 8'd16);
    goto(200, 5);  px(); chk_rgb("ntsc_cyan_h200", 8'd16, 8'd180, 8'd180);
    goto(719, 5);  px(); chk_rgb("ntsc_black_h719", 8'd16, 8'd16, 8'd16);
    check("ntsc_hblank_h719", 32'(HBlank), 32'd0);
    goto(720, 5);  px(); chk_rgb("ntsc_blank_h720", 8'd0, 8'd0, 8'd0);
    check("ntsc_hblank_h720", 32'(HBlank), 32'd1);
    goto(100, 239); px(); check("ntsc_vblank_239", 32'(VBlank), 32'd0);
    goto(100, 240); px(); check("ntsc_vblank_240", 32'(VBlank), 32'd1);
    chk_rgb("ntsc_vblank_rgb", 8'd0, 8'd0, 8'd0);
    goto(100, 243); px(); check("ntsc_vsync_243", 32'(VSync), 32'd0);
    goto(100, 244); px(); check("ntsc_vsync_244", 32'(VSync), 32'd1);
    goto(100, 246); px(); check("ntsc_vsync_246", 32'(VSync), 32'd1);
    goto(100, 247); px(); check("ntsc_vsync_247", 32'(VSync), 32'd0);
    goto(857, 261); px(); check("ntsc_last_line_vb", 32'(VBlank), 32'd1);
    px(); check("ntsc_wrap_vb", 32'(VBlank), 32'd0);
    chk_rgb("ntsc_wrap_white", 8'd180, 8'd180, 8'd180);

    // Mid-frame switch to PAL/full/100: current frame keeps NTSC geometry
    pal = 1'b1; range = 1'b1; smpte = 1'b1;
    goto(857, 260); px(); check("midframe_vb_260", 32'(VBlank), 32'd1);
    px(); check("midframe_vb_261", 32'(VBlank), 32'd1);
    goto(857, 261); px(); check("midframe_last_vb", 32'(VBlank), 32'd1);
    px(); check("midframe_wrap_vb", 32'(VBlank), 32'd0);
    chk_rgb("pal_full_white", 8'd255, 8'd255, 8'd255);
    goto(100, 10); px(); chk_rgb("pal_yellow_h100", 8'd255, 8'd255, 8'd0);
    goto(719, 10); px(); chk_rgb("pal_black_h719", 8'd0, 8'd0, 8'd0);
    goto(100, 287); px(); check("pal_vblank_287", 32'(VBlank), 32'd0);
    goto(100, 288); px(); check("pal_vblank_288", 32'(VBlank), 32'd1);
    goto(100, 289); px(); check("pal_vsync_289", 32'(VSync), 32'd0);
    goto(100, 290); px(); check("pal_vsync_290", 32'(VSync), 32'd1);
    goto(100, 292); px(); check("pal_vsync_292", 32'(VSync), 32'd1);
    goto(100, 293); px(); check("pal_vsync_293", 32'(VSync), 32'd0);
    goto(857, 311); px(); check("pal_last_line_vb", 32'(VBlank), 32'd1);
    px(); check("pal_wrap_312", 32'(VBlank), 32'd0);

    // Level change takes effect only at the next frame start
    range = 1'b0; smpte = 1'b0;
    goto(0, 20); px(); chk_rgb("level_held_midframe", 8'd255, 8'd255, 8'd255);
    goto(857, 311); px(); px();
    chk_rgb("limited75_white", 8'd180, 8'd180, 8'd180);
    goto(700, 10); px(); chk_rgb("limited_black", 8'd16, 8'd16, 8'd16);
    goto(799, 10); px(); check("hsync_799", 32'(HSync), 32'd1);
    goto(800, 10); px(); check("hsync_800", 32'(HSync), 32'd0);
    chk_rgb("limited_hblank_rgb", 8'd0, 8'd0, 8'd0);

    // Scan-doubled NTSC
    scandouble = 1'b1; pal = 1'b0;
    goto(857, 311); px(); px();
    while (ce_pix !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (ce_pix !== 1'b1 && n < 16);
    check("sd_ce_period", 32'(n), 32'd2);
    goto(100, 479); px(); check("sd_vblank_479", 32'(VBlank), 32'd0);
    goto(100, 480); px(); check("sd_vblank_480", 32'(VBlank), 32'd1);
    goto(100, 487); px(); check("sd_vsync_487", 32'(VSync), 32'd0);
    goto(100, 488); px(); check("sd_vsync_488", 32'(VSync), 32'd1);
    goto(100, 493); px(); check("sd_vsync_493", 32'(VSync), 32'd1);
    goto(100, 494); px(); check("sd_vsync_494", 32'(VSync), 32'd0);
    goto(300, 20); px(); chk_rgb("sd_row20_green", 8'd16, 8'd180, 8'd16);
    goto(300, 21); px(); chk_rgb("sd_row21_green", 8'd16, 8'd180, 8'd16);
    goto(857, 523); px(); check("sd_last_line_vb", 32'(VBlank), 32'd1);
    px(); check("sd_wrap_524", 32'(VBlank), 32'd0);

    // Reset mid-line
    goto(400, 10); px(); chk_rgb("pre_reset_magenta", 8'd180, 8'd16, 8'd180);
    reset = 1'b1;
    @(negedge clk);
    check("midline_reset_outputs", 32'({ce_pix, HBlank, HSync, VBlank, VSync, video_r, video_g, video_b}), 32'd0);
    reset = 1'b0;
    px(); chk_rgb("restart_white", 8'd180, 8'd180, 8'd180);
    first_hs = -1;
    n = 1;
    while (first_hs < 0 && n < 900) begin
      px();
      n++;
      if (HSync) first_hs = n;
    end
    check("restart_hsync_pixel", 32'(first_hs), 32'd737);

    goto(400, 100); px(); chk_rgb("row100_magenta", 8'd180, 8'd16, 8'd180);
    goto(400, 200); px();
`ifdef TESTPAT_RAMP_EN
    chk_rgb("row200_ramp", 8'd100, 8'd100, 8'd100);
`else
    chk_rgb("row200_magenta", 8'd180, 8'd16, 8'd180);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
